// File: rtl/mx_out_pkg.sv
// Purpose: shared types, widths and format tags for the MX block output serializer.
// Contents: block/row/entry payload types, format tag constants, FSM state type,
//           and a row-extraction helper that maps row index to the packed layout.
package mx_out_pkg;

    localparam int unsigned ROWS     = 8;
    localparam int unsigned COLS     = 8;
    localparam int unsigned ELEM_W   = 8;
    localparam int unsigned EXP_W    = 8;
    localparam int unsigned FMT_W    = 4;
    localparam int unsigned ROW_W    = $clog2(ROWS);
    localparam int unsigned ROW_BITS = COLS * ELEM_W;
    localparam int unsigned BLK_BITS = ROWS * ROW_BITS;

    typedef logic [COLS-1:0][ELEM_W-1:0] row_t;
    typedef row_t [ROWS-1:0]             block_t;

    typedef struct packed {
        logic [1:0] prec_mode;
        logic [1:0] fp_mode;
    } fmt_t;

    typedef struct packed {
        block_t           data;
        logic [EXP_W-1:0] exp;
        fmt_t             fmt;
    } entry_t;

    localparam logic [FMT_W-1:0] FMT_INT8 = 4'b0000;
    localparam logic [FMT_W-1:0] FMT_E4M3 = 4'b0110;
    localparam logic [FMT_W-1:0] FMT_E3M2 = 4'b0101;
    localparam logic [FMT_W-1:0] FMT_E5M2 = 4'b0111;
    localparam logic [FMT_W-1:0] FMT_E2M3 = 4'b0100;
    localparam logic [FMT_W-1:0] FMT_E2M1 = 4'b1100;

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } state_t;

    // Row 0 occupies the MSBs of the packed block, so row r sits at index ROWS-1-r.
    function automatic row_t get_row(input block_t blk, input logic [ROW_W-1:0] r);
        return blk[ROW_W'(ROWS - 1) - r];
    endfunction

endpackage

// File: rtl/mx_block_buffer.sv
// Purpose: DEPTH-entry FIFO of whole MX blocks (data, shared exponent, format tag).
// Ports:
//   clk, rst     clock, asynchronous active-high reset (pointers and count only)
//   wr_en        push wr_entry (caller guarantees not full)
//   wr_entry     block to store
//   rd_en        pop the head entry (caller guarantees not empty)
//   head_blk     element data of the head entry
//   next_entry   entry behind the head, used when the head is popped
//   count        number of entries held
module mx_block_buffer
    import mx_out_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  entry_t                       wr_entry,
    input  logic                         rd_en,
    output block_t                       head_blk,
    output entry_t                       next_entry,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Storage needs no reset; count qualifies every entry.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= inc(wr_ptr);
            end
            if (rd_en) begin
                rd_ptr <= inc(rd_ptr);
            end
            if (wr_en && !rd_en) begin
                count <= count + CNT_W'(1);
            end else if (!wr_en && rd_en) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign head_blk   = mem[rd_ptr].data;
    assign next_entry = mem[inc(rd_ptr)];

endmodule

// File: rtl/mx_block_out_serializer.sv
// Purpose: buffers requantized 8x8 MX output blocks from the Block PE and streams
//          them one row per beat over a valid/ready bus toward the TCDM writer.
// Ports:
//   clk_i, rst_i              clock, asynchronous active-high reset
//   blk_valid_i/blk_ready_o   block handshake from the PE (ready depends on state only)
//   blk_data_i/exp_i/fmt_i    block elements (row 0 in MSBs), shared exponent, format tag
//   tx_valid_o/tx_ready_i     row beat handshake toward the sink
//   tx_data_o                 row elements, element 0 in MSBs
//   tx_row_o/tx_last_o        row index, final row of the block
//   tx_exp_o/tx_fmt_o         exponent and format of the block being sent
//   busy_o                    at least one block buffered
module mx_block_out_serializer
    import mx_out_pkg::*;
#(
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                blk_valid_i,
    output logic                blk_ready_o,
    input  logic [BLK_BITS-1:0] blk_data_i,
    input  logic [EXP_W-1:0]    blk_exp_i,
    input  logic [FMT_W-1:0]    blk_fmt_i,
    output logic                tx_valid_o,
    input  logic                tx_ready_i,
    output logic [ROW_BITS-1:0] tx_data_o,
    output logic [ROW_W-1:0]    tx_row_o,
    output logic                tx_last_o,
    output logic [EXP_W-1:0]    tx_exp_o,
    output logic [FMT_W-1:0]    tx_fmt_o,
    output logic                busy_o
);

    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

    entry_t           in_entry;
    entry_t           next_entry;
    entry_t           load_src;
    block_t           head_blk;
    logic [CNT_W-1:0] count;
    logic             accept;
    logic             pop;
    logic             pop_last;
    logic             load;

    state_t           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    row_t             data_q, data_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    fmt_t             fmt_q, fmt_d;

    assign in_entry    = {blk_data_i, blk_exp_i, blk_fmt_i};
    assign blk_ready_o = ~rst_i & (count != CNT_W'(BUF_DEPTH));
    assign accept      = blk_valid_i & blk_ready_o;
    assign pop         = valid_q & tx_ready_i;
    assign pop_last    = pop & last_q;
    assign busy_o      = (count != '0);

    mx_block_buffer #(
        .DEPTH(BUF_DEPTH)
    ) u_buf (
        .clk       (clk_i),
        .rst       (rst_i),
        .wr_en     (accept),
        .wr_entry  (in_entry),
        .rd_en     (pop_last),
        .head_blk  (head_blk),
        .next_entry(next_entry),
        .count     (count)
    );

    // Next-state and registered-beat computation.
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        valid_d  = valid_q;
        last_d   = last_q;
        data_d   = data_q;
        exp_d    = exp_q;
        fmt_d    = fmt_q;
        load     = 1'b0;
        load_src = in_entry;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    load    = 1'b1;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (pop && !last_q) begin
                    row_d  = row_q + ROW_W'(1);
                    last_d = (row_d == ROW_W'(ROWS - 1));
                    data_d = get_row(head_blk, row_d);
                end else if (pop_last) begin
                    // Next block is either already queued behind the head or arriving now.
                    if (count > CNT_W'(1)) begin
                        load     = 1'b1;
                        load_src = next_entry;
                    end else if (accept) begin
                        load = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load) begin
            row_d   = '0;
            valid_d = 1'b1;
            last_d  = (ROWS == 1);
            data_d  = get_row(load_src.data, '0);
            exp_d   = load_src.exp;
            fmt_d   = load_src.fmt;
        end
    end

    // State and beat registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
            exp_q   <= '0;
            fmt_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            data_q  <= data_d;
            exp_q   <= exp_d;
            fmt_q   <= fmt_d;
        end
    end

    assign tx_valid_o = valid_q;
    assign tx_data_o  = data_q;
    assign tx_row_o   = row_q;
    assign tx_last_o  = last_q;
    assign tx_exp_o   = exp_q;
    assign tx_fmt_o   = fmt_q;

endmodule

// File: tb/tb_mx_block_out_serializer.sv
// Purpose: directed self-checking bench for mx_block_out_serializer (BUF_DEPTH = 2).
module tb_mx_block_out_serializer;
    import mx_out_pkg::*;

    localparam int unsigned DEPTH = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic [7:0]   blk_exp;
    logic [3:0]   blk_fmt;
    logic         tx_valid;
    logic         tx_ready;
    logic [63:0]  tx_data;
    logic [2:0]   tx_row;
    logic         tx_last;
    logic [7:0]   tx_exp;
    logic [3:0]   tx_fmt;
    logic         busy;

    mx_block_out_serializer #(.BUF_DEPTH(DEPTH)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .blk_valid_i(blk_valid),
        .blk_ready_o(blk_ready),
        .blk_data_i (blk_data),
        .blk_exp_i  (blk_exp),
        .blk_fmt_i  (blk_fmt),
        .tx_valid_o (tx_valid),
        .tx_ready_i (tx_ready),
        .tx_data_o  (tx_data),
        .tx_row_o   (tx_row),
        .tx_last_o  (tx_last),
        .tx_exp_o   (tx_exp),
        .tx_fmt_o   (tx_fmt),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [511:0] data;
        logic [7:0]   exp;
        logic [3:0]   fmt;
    } sb_t;

    sb_t sb_q[$];
    int  cnt_m = 0;
    int  row_m = 0;
    int  compared = 0;
    int  mismatched = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // element [r][c] = {r, c} ^ xv, row 0 / element 0 in the MSBs
    function automatic logic [511:0] mk_blk(input logic [7:0] xv);
        logic [511:0] b;
        b = '0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                b[(7-r)*64 + (7-c)*8 +: 8] = {4'(r), 4'(c)} ^ xv;
        return b;
    endfunction

    // One clock: model checks before the edge, scoreboard on beats, stall stability after.
    task automatic cycle(input bit rand_ready);
        logic        acc, beat, stall;
        logic [63:0] s_data;
        logic [2:0]  s_row;
        logic        s_last;
        logic [7:0]  s_exp;
        sb_t         e;
        if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
        check("blk_ready", 64'(blk_ready), 64'(cnt_m != DEPTH));
        check("busy", 64'(busy), 64'(cnt_m != 0));
        check("tx_valid", 64'(tx_valid), 64'(cnt_m != 0));
        beat  = (cnt_m != 0) && tx_ready;
        stall = (cnt_m != 0) && !tx_ready;
        acc   = blk_valid && (cnt_m != DEPTH);
        s_data = tx_data; s_row = tx_row; s_last = tx_last; s_exp = tx_exp;
        if (beat) begin
            e = sb_q[0];
            check("beat_data", tx_data, e.data[(7-row_m)*64 +: 64]);
            check("beat_row", 64'(tx_row), 64'(row_m));
            check("beat_last", 64'(tx_last), 64'(row_m == 7));
            check("beat_exp", 64'(tx_exp), 64'(e.exp));
            check("beat_fmt", 64'(tx_fmt), 64'(e.fmt));
            row_m++;
            if (row_m == 8) begin
                row_m = 0;
                void'(sb_q.pop_front());
                cnt_m--;
            end
        end
        if (acc) begin
            e.data = blk_data; e.exp = blk_exp; e.fmt = blk_fmt;
            sb_q.push_back(e);
            cnt_m++;
        end
        @(posedge clk); #1;
        if (acc) blk_valid = 1'b0;
        if (stall) begin
            check("stall_valid", 64'(tx_valid), 64'(1));
            check("stall_data", tx_data, s_data);
            check("stall_row", 64'(tx_row), 64'(s_row));
            check("stall_last", 64'(tx_last), 64'(s_last));
            check("stall_exp", 64'(tx_exp), 64'(s_exp));
        end
    endtask

    task automatic present(input logic [511:0] d, input logic [7:0] x, input logic [3:0] f);
        blk_data = d; blk_exp = x; blk_fmt = f; blk_valid = 1'b1;
    endtask

    task automatic send(input logic [511:0] d, input logic [7:0] x, input logic [3:0] f);
        present(d, x, f);
        cycle(1'b0);
    endtask

    task automatic run(input bit rand_ready, input int budget);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || blk_valid) && n < budget) begin
            cycle(rand_ready);
            n++;
        end
        check("run_timeout", 64'(sb_q.size() + int'(blk_valid)), 64'(0));
    endtask

    initial begin
        rst = 1'b1; blk_valid = 1'b0; tx_ready = 1'b0;
        blk_data = '0; blk_exp = '0; blk_fmt = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_valid", 64'(tx_valid), 64'(0));
        check("rst_last", 64'(tx_last), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_data", tx_data, 64'(0));
        check("rst_row", 64'(tx_row), 64'(0));
        check("rst_ready", 64'(blk_ready), 64'(1));

        // 1: uniform INT8 block, sink always ready, first beat right after accept
        tx_ready = 1'b1;
        send({64{8'h2C}}, 8'd121, FMT_INT8);
        for (int r = 0; r < 8; r++) begin
            check("t1_data", tx_data, 64'h2C2C_2C2C_2C2C_2C2C);
            check("t1_exp", 64'(tx_exp), 64'd121);
            check("t1_last", 64'(tx_last), 64'(r == 7));
            cycle(1'b0);
        end
        check("t1_idle", 64'(tx_valid), 64'(0));

        // 2: row-distinct block, byte ordering
        send(mk_blk(8'h00), 8'd127, FMT_E4M3);
        for (int r = 0; r < 8; r++) begin
            check("t2_data", tx_data, 64'h0001_0203_0405_0607 + 64'(r) * 64'h1010_1010_1010_1010);
            check("t2_row", 64'(tx_row), 64'(r));
            check("t2_fmt", 64'(tx_fmt), 64'(FMT_E4M3));
            cycle(1'b0);
        end

        // 3: three blocks against a blocked sink
        tx_ready = 1'b0;
        send(mk_blk(8'h11), 8'd113, FMT_E5M2);
        check("t3_ready1", 64'(blk_ready), 64'(1));
        send(mk_blk(8'h22), 8'd125, FMT_E2M3);
        check("t3_ready2", 64'(blk_ready), 64'(0));
        present(mk_blk(8'h33), 8'd130, FMT_E2M1);
        repeat (3) cycle(1'b0);
        check("t3_hold_exp", 64'(tx_exp), 64'd113);
        tx_ready = 1'b1;
        run(1'b0, 100);

        // 4: random sink stalls over two blocks
        tx_ready = 1'b0;
        send(mk_blk(8'h80), 8'd10, FMT_E3M2);
        send(mk_blk(8'hC5), 8'd20, FMT_INT8);
        run(1'b1, 400);

        // 5: full buffer, new block offered on the final beat of the head block
        tx_ready = 1'b0;
        send(mk_blk(8'h01), 8'd1, FMT_INT8);
        send(mk_blk(8'h02), 8'd2, FMT_INT8);
        present(mk_blk(8'h03), 8'd3, FMT_INT8);
        tx_ready = 1'b1;
        repeat (7) cycle(1'b0);
        check("t5_last", 64'(tx_last), 64'(1));
        check("t5_full_ready", 64'(blk_ready), 64'(0));
        cycle(1'b0);
        check("t5_ready_after", 64'(blk_ready), 64'(1));
        check("t5_next_exp", 64'(tx_exp), 64'd2);
        check("t5_next_row", 64'(tx_row), 64'(0));
        run(1'b0, 100);

        // 6: reset mid-block with another block queued
        tx_ready = 1'b0;
        send(mk_blk(8'h40), 8'd40, FMT_E4M3);
        send(mk_blk(8'h41), 8'd41, FMT_E4M3);
        tx_ready = 1'b1;
        repeat (3) cycle(1'b0);
        tx_ready = 1'b0;
        check("t6_row3", 64'(tx_row), 64'(3));
        rst = 1'b1;
        #1;
        check("t6_rst_valid", 64'(tx_valid), 64'(0));
        check("t6_rst_busy", 64'(busy), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        sb_q.delete();
        cnt_m = 0;
        row_m = 0;
        check("t6_ready", 64'(blk_ready), 64'(1));
        check("t6_valid", 64'(tx_valid), 64'(0));
        tx_ready = 1'b1;
        send(mk_blk(8'h50), 8'd50, FMT_E5M2);
        check("t6_new_row", 64'(tx_row), 64'(0));
        check("t6_new_exp", 64'(tx_exp), 64'd50);
        run(1'b0, 100);
        check("end_idle", 64'(tx_valid), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
